ips2l_pcie_dma_rx_tlp_decode: RTL and testbench
===============================================

// Module: ips2l_pcie_dma_rx_tlp_decode
// PURPOSE
// - Receive-side TLP decoder for the PCIe DMA engine; peer of the DMA TX path.
// - Accepts 128-bit TLP beats from the core AXIS master port and classifies each TLP.
// - MWr to BAR0 is written into BAR0 RAM. MWr to BAR1 is a 32-bit DMA-register write.
// - MRd is forwarded as a completion request to the TX CplD generator. CplD payload is written into BAR2 RAM and its tag is released.
// PARAMETERS
// ADDR_WIDTH  9  word (128-bit) address width of BAR0/BAR2 RAMs
// PORTS
// clk                    in   1    core user clock (gen1 62.5MHz, gen2 125MHz)
// rst                    in   1    synchronous, active-high reset
// i_axis_master_tvld     in   1    beat valid
// o_axis_master_trdy     out  1    beat ready
// i_axis_master_tdata    in   128  beat data, DW0 at [31:0]
// i_axis_master_tlast    in   1    last beat of TLP
// i_axis_master_tuser    in   6    one-hot BAR hit, valid on header beat
// o_bar0_wr_en/addr/data/be  out 1/ADDR_WIDTH/128/16  BAR0 RAM write
// o_bar1_wr_en/addr/data out  1/8/32    DMA register write (addr = byte addr[7:0])
// o_bar2_wr_en/addr/data/be  out 1/ADDR_WIDTH/128/16  BAR2 RAM write (CplD data)
// o_mrd_tc/attr/length/id/tag/addr  out 3/3/10/16/8/64  latched MRd fields
// o_cpld_req_vld         out  1    completion request valid
// i_cpld_req_rdy         in   1    TX accepts request
// o_cpld_rcv             out  1    1-cycle pulse: final CplD for a tag received
// o_cpld_tag             out  8    tag released with o_cpld_rcv
// o_unsupported          out  1    1-cycle pulse: TLP dropped
// i_rx_restart           in   1    clears BAR2 write pointer
// BEHAVIOUR
// - Reset: state IDLE; every output 0 except trdy=1; BAR2 pointer 0.
// - Beat 0 is always header (DW0..DW3, DW3 unused for 3DW). Payload starts at beat 1, DW0 in lane [31:0].
// - Header decode uses DW0[31:24]:
//   - MRd32 00, MRd64 20, MWr32 40, MWr64 60, CplD 4A.
//   - Cpl 0A and all other types go to DISCARD with o_unsupported.
// - Header fields:
//   - len = DW0[9:0]; 0 means 1024 DW.
//   - DW1: id=[31:16], tag=[15:8], lastBE=[7:4], firstBE=[3:0].
//   - addr32 = DW2; addr64 = {DW2,DW3}. CplD: byte count = DW1[11:0], tag = DW2[15:8].
// - FSM states: IDLE, MWR_DATA, CPLD_DATA, MRD_HOLD, DISCARD.
// - IDLE (trdy=1), on accepted header:
//   - MWr with BAR0 hit -> MWR_DATA.
//   - MWr with BAR1 hit -> MWR_DATA, register mode.
//   - MRd (any BAR) -> MRD_HOLD.
//   - CplD -> CPLD_DATA.
//   - else -> DISCARD.
//   - Header with tlast=1 on MWr/CplD is malformed -> o_unsupported, stay IDLE.
// - MWR_DATA/CPLD_DATA: trdy=1, never stalls.
//   - rem (11b) loads len; each beat writes lanes min(rem,4); rem -= 4 saturating at 0.
//   - Byte enables: first payload DW uses firstBE; last DW uses lastBE (firstBE if len=1); middle DWs F; unused lanes 0.
//   - BAR0 address = addr[ADDR_WIDTH+3:4] + beat index, wraps mod 2^ADDR_WIDTH; hosts issue 16B-aligned writes.
//   - BAR1: only payload DW0 written, data=lane0, addr=addr[7:0]; remaining DWs ignored.
//   - BAR2 address = pointer; pointer += 1 per beat with any lane enabled, wraps.
//   - Write strobes are registered: 1 cycle after beat handshake.
//   - Beats after rem=0 are consumed without writing. tlast returns to IDLE.
// - CplD last: if byte count <= len*4, pulse o_cpld_rcv with o_cpld_tag on the cycle tlast is accepted.
// - MRD_HOLD:
//   - trdy=0; o_mrd_* held stable; o_cpld_req_vld=1.
//   - On vld & rdy: vld drops next cycle, state -> IDLE.
//   - o_mrd_addr = {32'b0,addr32} for MRd32.
// - DISCARD: trdy=1 until tlast beat, then IDLE.
// - i_rx_restart same cycle as a BAR2 write: that write uses the old pointer; pointer becomes 0.
// - rst mid-TLP: abort immediately, no further writes, remaining beats of that TLP decode as a new header (core resets too).
// TESTING
// - MWr32 BAR0, addr 0x40, len 8, BE F/F, 2 data beats -> bar0 writes at addr 4,5, be FFFF each, 1 cycle after each beat.
// - MWr32 BAR1, addr 0x10, len 1, firstBE F, data 0x1234 -> one o_bar1_wr, addr 0x10, data 0x1234.
// - MRd64 tag 0x05 len 16, i_cpld_req_rdy held 0 for 5 cycles -> trdy=0, vld=1 5 cycles, fields stable, IDLE after rdy.
// - CplD tag 0x07, len 4, byte count 16 -> one bar2 write at pointer, o_cpld_rcv pulse, tag 07. Byte count 64 -> no o_cpld_rcv.
// - Cpl (0A) header and MWr with header tlast=1 -> o_unsupported pulse, no writes, next TLP decoded normally.
// - rst asserted mid MWr len 32 -> all outputs 0 next cycle, no further bar0 writes.

Source files
------------

// File: rtl/ips2l_pcie_dma_rx_tlp_decode.sv
// Receive-side TLP decoder for the PCIe DMA engine: classifies 128-bit AXIS beats
// into BAR0 RAM writes, BAR1 register writes, BAR2 completion-data writes and MRd requests.
module ips2l_pcie_dma_rx_tlp_decode #(
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_axis_master_tvld,
   output logic                  o_axis_master_trdy,
   input  logic [127:0]          i_axis_master_tdata,
   input  logic                  i_axis_master_tlast,
   input  logic [5:0]            i_axis_master_tuser,
   output logic                  o_bar0_wr_en,
   output logic [ADDR_WIDTH-1:0] o_bar0_wr_addr,
   output logic [127:0]          o_bar0_wr_data,
   output logic [15:0]           o_bar0_wr_be,
   output logic                  o_bar1_wr_en,
   output logic [7:0]            o_bar1_wr_addr,
   output logic [31:0]           o_bar1_wr_data,
   output logic                  o_bar2_wr_en,
   output logic [ADDR_WIDTH-1:0] o_bar2_wr_addr,
   output logic [127:0]          o_bar2_wr_data,
   output logic [15:0]           o_bar2_wr_be,
   output logic [2:0]            o_mrd_tc,
   output logic [2:0]            o_mrd_attr,
   output logic [9:0]            o_mrd_length,
   output logic [15:0]           o_mrd_id,
   output logic [7:0]            o_mrd_tag,
   output logic [63:0]           o_mrd_addr,
   output logic                  o_cpld_req_vld,
   input  logic                  i_cpld_req_rdy,
   output logic                  o_cpld_rcv,
   output logic [7:0]            o_cpld_tag,
   output logic                  o_unsupported,
   input  logic                  i_rx_restart
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_MWR_DATA  = 3'd1;
   localparam logic [2:0] S_CPLD_DATA = 3'd2;
   localparam logic [2:0] S_MRD_HOLD  = 3'd3;
   localparam logic [2:0] S_DISCARD   = 3'd4;

   logic [2:0]            state;
   logic [10:0]           rem;
   logic                  first_beat;
   logic                  reg_mode;
   logic [3:0]            first_be;
   logic [3:0]            last_be;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [7:0]            reg_addr;
   logic [ADDR_WIDTH-1:0] bar2_ptr;
   logic [7:0]            cpl_tag;
   logic                  bc_ok;

   // Header field views of the current beat
   logic [7:0]  fmt_type;
   logic [31:0] dw0, dw1, dw2, dw3;
   logic [31:0] addr_lo;
   logic [10:0] len_eff;
   logic [12:0] bc_eff;
   logic        is_mrd, is_mwr, is_cpld;

   assign dw0      = i_axis_master_tdata[31:0];
   assign dw1      = i_axis_master_tdata[63:32];
   assign dw2      = i_axis_master_tdata[95:64];
   assign dw3      = i_axis_master_tdata[127:96];
   assign fmt_type = dw0[31:24];
   assign is_mrd   = (fmt_type == 8'h00) || (fmt_type == 8'h20);
   assign is_mwr   = (fmt_type == 8'h40) || (fmt_type == 8'h60);
   assign is_cpld  = (fmt_type == 8'h4A);
   assign addr_lo  = fmt_type[5] ? dw3 : dw2;
   assign len_eff  = (dw0[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw0[9:0]};
   assign bc_eff   = (dw1[11:0] == 12'd0) ? 13'd4096 : {1'b0, dw1[11:0]};

   logic unused_bits;
   assign unused_bits = ^{i_axis_master_tuser[5:2], addr_lo[31:ADDR_WIDTH+4]};

   logic       data_state;
   logic       data_beat;
   logic [2:0] lanes;
   logic [15:0] be_vec;
   logic       bar2_write;

   assign data_state = (state == S_MWR_DATA) || (state == S_CPLD_DATA);
   assign data_beat  = data_state && i_axis_master_tvld;
   assign lanes      = (rem > 11'd3) ? 3'd4 : rem[2:0];
   assign bar2_write = (state == S_CPLD_DATA) && i_axis_master_tvld && (lanes != 3'd0);

   // First payload DW takes firstBE (which also covers len=1), final DW takes lastBE.
   always_comb begin
      be_vec = '0;
      for (int i = 0; i < 4; i++) begin
         if (3'(i) < lanes) begin
            if (first_beat && i == 0)
               be_vec[i*4 +: 4] = first_be;
            else if (rem <= 11'd4 && 3'(i) == lanes - 3'd1)
               be_vec[i*4 +: 4] = last_be;
            else
               be_vec[i*4 +: 4] = 4'hF;
         end
      end
   end

   assign o_axis_master_trdy = (state != S_MRD_HOLD);
   assign o_cpld_req_vld     = (state == S_MRD_HOLD);
   assign o_cpld_rcv         = (state == S_CPLD_DATA) && i_axis_master_tvld &&
                               i_axis_master_tlast && bc_ok;
   assign o_cpld_tag         = o_cpld_rcv ? cpl_tag : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         rem            <= '0;
         first_beat     <= 1'b0;
         reg_mode       <= 1'b0;
         first_be       <= '0;
         last_be        <= '0;
         word_addr      <= '0;
         reg_addr       <= '0;
         bar2_ptr       <= '0;
         cpl_tag        <= '0;
         bc_ok          <= 1'b0;
         o_bar0_wr_en   <= 1'b0;
         o_bar0_wr_addr <= '0;
         o_bar0_wr_data <= '0;
         o_bar0_wr_be   <= '0;
         o_bar1_wr_en   <= 1'b0;
         o_bar1_wr_addr <= '0;
         o_bar1_wr_data <= '0;
         o_bar2_wr_en   <= 1'b0;
         o_bar2_wr_addr <= '0;
         o_bar2_wr_data <= '0;
         o_bar2_wr_be   <= '0;
         o_mrd_tc       <= '0;
         o_mrd_attr     <= '0;
         o_mrd_length   <= '0;
         o_mrd_id       <= '0;
         o_mrd_tag      <= '0;
         o_mrd_addr     <= '0;
         o_unsupported  <= 1'b0;
      end else begin
         // NOTE: strobes default low every cycle so each write/drop is a single-cycle pulse.
         o_bar0_wr_en  <= 1'b0;
         o_bar1_wr_en  <= 1'b0;
         o_bar2_wr_en  <= 1'b0;
         o_unsupported <= 1'b0;

         // Restart wins over the increment; a write in the same cycle already latched the old pointer.
         if (i_rx_restart)
            bar2_ptr <= '0;
         else if (bar2_write)
            bar2_ptr <= bar2_ptr + 1'b1;

         case (state)
            S_IDLE: begin
               if (i_axis_master_tvld) begin
                  if (is_mrd) begin
                     o_mrd_tc     <= dw0[22:20];
                     o_mrd_attr   <= {dw0[18], dw0[13:12]};
                     o_mrd_length <= dw0[9:0];
                     o_mrd_id     <= dw1[31:16];
                     o_mrd_tag    <= dw1[15:8];
                     o_mrd_addr   <= fmt_type[5] ? {dw2, dw3} : {32'h0, dw2};
                     state        <= S_MRD_HOLD;
                  end else if (is_cpld || (is_mwr && (i_axis_master_tuser[0] || i_axis_master_tuser[1]))) begin
                     if (i_axis_master_tlast) begin
                        o_unsupported <= 1'b1;
                     end else begin
                        state      <= is_cpld ? S_CPLD_DATA : S_MWR_DATA;
                        rem        <= len_eff;
                        first_beat <= 1'b1;
                        reg_mode   <= !i_axis_master_tuser[0];
                        first_be   <= is_cpld ? 4'hF : dw1[3:0];
                        last_be    <= is_cpld ? 4'hF : dw1[7:4];
                        word_addr  <= addr_lo[ADDR_WIDTH+3:4];
                        reg_addr   <= addr_lo[7:0];
                        cpl_tag    <= dw2[15:8];
                        bc_ok      <= (bc_eff <= {len_eff, 2'b00});
                     end
                  end else begin
                     o_unsupported <= 1'b1;
                     if (!i_axis_master_tlast)
                        state <= S_DISCARD;
                  end
               end
            end

            S_MWR_DATA, S_CPLD_DATA: begin
               if (data_beat) begin
                  if (state == S_MWR_DATA && !reg_mode && lanes != 3'd0) begin
                     o_bar0_wr_en   <= 1'b1;
                     o_bar0_wr_addr <= word_addr;
                     o_bar0_wr_data <= i_axis_master_tdata;
                     o_bar0_wr_be   <= be_vec;
                  end
                  if (state == S_MWR_DATA && reg_mode && first_beat) begin
                     o_bar1_wr_en   <= 1'b1;
                     o_bar1_wr_addr <= reg_addr;
                     o_bar1_wr_data <= dw0;
                  end
                  if (bar2_write) begin
                     o_bar2_wr_en   <= 1'b1;
                     o_bar2_wr_addr <= bar2_ptr;
                     o_bar2_wr_data <= i_axis_master_tdata;
                     o_bar2_wr_be   <= be_vec;
                  end
                  rem        <= (rem > 11'd3) ? rem - 11'd4 : 11'd0;
                  first_beat <= 1'b0;
                  word_addr  <= word_addr + 1'b1;
                  if (i_axis_master_tlast)
                     state <= S_IDLE;
               end
            end

            S_MRD_HOLD: begin
               if (i_cpld_req_rdy)
                  state <= S_IDLE;
            end

            S_DISCARD: begin
               if (i_axis_master_tvld && i_axis_master_tlast)
                  state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ips2l_pcie_dma_rx_tlp_decode.sv
// Directed bench for the RX TLP decoder: one task per scenario with inline expected values.
module tb_ips2l_pcie_dma_rx_tlp_decode;

   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic          tvld;
   logic          trdy;
   logic [127:0]  tdata;
   logic          tlast;
   logic [5:0]    tuser;
   logic          b0_en, b1_en, b2_en;
   logic [AW-1:0] b0_addr, b2_addr;
   logic [127:0]  b0_data, b2_data;
   logic [15:0]   b0_be, b2_be;
   logic [7:0]    b1_addr;
   logic [31:0]   b1_data;
   logic [2:0]    mrd_tc, mrd_attr;
   logic [9:0]    mrd_length;
   logic [15:0]   mrd_id;
   logic [7:0]    mrd_tag;
   logic [63:0]   mrd_addr;
   logic          req_vld, req_rdy;
   logic          cpld_rcv;
   logic [7:0]    cpld_tag;
   logic          unsupported;
   logic          rx_restart;

   always #5 clk = ~clk;

   ips2l_pcie_dma_rx_tlp_decode #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .i_axis_master_tvld(tvld), .o_axis_master_trdy(trdy),
      .i_axis_master_tdata(tdata), .i_axis_master_tlast(tlast), .i_axis_master_tuser(tuser),
      .o_bar0_wr_en(b0_en), .o_bar0_wr_addr(b0_addr), .o_bar0_wr_data(b0_data), .o_bar0_wr_be(b0_be),
      .o_bar1_wr_en(b1_en), .o_bar1_wr_addr(b1_addr), .o_bar1_wr_data(b1_data),
      .o_bar2_wr_en(b2_en), .o_bar2_wr_addr(b2_addr), .o_bar2_wr_data(b2_data), .o_bar2_wr_be(b2_be),
      .o_mrd_tc(mrd_tc), .o_mrd_attr(mrd_attr), .o_mrd_length(mrd_length),
      .o_mrd_id(mrd_id), .o_mrd_tag(mrd_tag), .o_mrd_addr(mrd_addr),
      .o_cpld_req_vld(req_vld), .i_cpld_req_rdy(req_rdy),
      .o_cpld_rcv(cpld_rcv), .o_cpld_tag(cpld_tag),
      .o_unsupported(unsupported), .i_rx_restart(rx_restart)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int hs_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0] addr;
      logic [127:0]  data;
      logic [15:0]   be;
      int            cyc;
   } wr_t;

   wr_t        b0_q[$];
   wr_t        b2_q[$];
   wr_t        mon_w;
   int         n_b1 = 0;
   logic [7:0] last_b1_addr;
   logic [31:0] last_b1_data;
   int         n_rcv = 0;
   logic [7:0] last_rcv_tag;
   int         rcv_cyc;
   int         n_unsup = 0;

   // Passive recorder of every write strobe and pulse, sampled mid-cycle
   always @(negedge clk) begin
      if (b0_en) begin
         mon_w.addr = b0_addr; mon_w.data = b0_data; mon_w.be = b0_be; mon_w.cyc = cyc;
         b0_q.push_back(mon_w);
      end
      if (b2_en) begin
         mon_w.addr = b2_addr; mon_w.data = b2_data; mon_w.be = b2_be; mon_w.cyc = cyc;
         b2_q.push_back(mon_w);
      end
      if (b1_en) begin
         n_b1++; last_b1_addr = b1_addr; last_b1_data = b1_data;
      end
      if (cpld_rcv) begin
         n_rcv++; last_rcv_tag = cpld_tag; rcv_cyc = cyc;
      end
      if (unsupported) n_unsup++;
   end

   function automatic logic [31:0] mk_dw0(input logic [7:0] ft, input logic [2:0] tc,
                                          input logic [2:0] attr, input logic [9:0] len);
      return {ft, 1'b0, tc, 1'b0, attr[2], 4'b0, attr[1:0], 2'b0, len};
   endfunction

   // Present one beat, hold it until accepted, then drop valid.
   task automatic send(input logic [127:0] d, input logic last, input logic [5:0] user);
      logic ok;
      int   n;
      tvld = 1'b1; tdata = d; tlast = last; tuser = user; n = 0;
      do begin
         @(negedge clk); ok = trdy;
         @(posedge clk); #2; n++;
      end while (!ok && n < 40);
      hs_cyc = cyc;
      tvld = 1'b0; tlast = 1'b0; tdata = '0; tuser = '0;
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: trdy stayed %b, required 1", trdy);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1; tvld = 1'b0; tdata = '0; tlast = 1'b0; tuser = '0;
      req_rdy = 1'b0; rx_restart = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      n_cmp++; if (trdy !== 1'b1) begin n_bad++; $display("FAIL reset_trdy: got %b want 1", trdy); end
      n_cmp++; if (req_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", req_vld); end
      n_cmp++; if ({b0_en, b1_en, b2_en} !== 3'b000) begin n_bad++; $display("FAIL reset_wr_en: got %b want 000", {b0_en, b1_en, b2_en}); end
      n_cmp++; if ({unsupported, cpld_rcv} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses: got %b want 00", {unsupported, cpld_rcv}); end
      n_cmp++; if (mrd_addr !== 64'h0) begin n_bad++; $display("FAIL reset_mrd_addr: got %h want 0", mrd_addr); end
      n_cmp++; if ({mrd_tag, mrd_id, mrd_length} !== 34'h0) begin n_bad++; $display("FAIL reset_mrd_fields: got %h want 0", {mrd_tag, mrd_id, mrd_length}); end
      n_cmp++; if (b0_addr !== '0 || b0_data !== '0 || b0_be !== '0) begin n_bad++; $display("FAIL reset_bar0_bus: got %h/%h/%h want 0", b0_addr, b0_be, b0_data); end
      n_cmp++; if (cpld_tag !== 8'h0) begin n_bad++; $display("FAIL reset_cpld_tag: got %h want 0", cpld_tag); end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_mwr_bar0();
      logic [127:0] d0, d1, d2, d3;
      int c0, c1;
      d0 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
      d1 = 128'h1f1e1d1c_1b1a1918_17161514_13121110;
      d2 = 128'hdeadbeef_cafef00d_01234567_89abcdef;
      d3 = 128'h55555555_aaaaaaaa_76543210_fedcba98;
      b0_q.delete();
      // MWr32 addr 0x40 len 8, BE F/F
      send({32'h0, 32'h0000_0040, 32'h0100_01FF, mk_dw0(8'h40, 3'd0, 3'd0, 10'd8)}, 1'b0, 6'b000001);
      send(d0, 1'b0, 6'b000001); c0 = hs_cyc;
      send(d1, 1'b1, 6'b000001); c1 = hs_cyc;
      idle(3);
      n_cmp++; if (b0_q.size() != 2) begin n_bad++; $display("FAIL mwr32_count: got %0d want 2", b0_q.size()); end
      if (b0_q.size() == 2) begin
         n_cmp++; if (b0_q[0].addr !== 9'd4 || b0_q[1].addr !== 9'd5) begin n_bad++; $display("FAIL mwr32_addr: got %h,%h want 004,005", b0_q[0].addr, b0_q[1].addr); end
         n_cmp++; if (b0_q[0].be !== 16'hFFFF || b0_q[1].be !== 16'hFFFF) begin n_bad++; $display("FAIL mwr32_be: got %h,%h want ffff,ffff", b0_q[0].be, b0_q[1].be); end
         n_cmp++; if (b0_q[0].data !== d0 || b0_q[1].data !== d1) begin n_bad++; $display("FAIL mwr32_data: got %h want %h", b0_q[0].data, d0); end
         n_cmp++; if (b0_q[0].cyc != c0 || b0_q[1].cyc != c1) begin n_bad++; $display("FAIL mwr32_latency: got cyc %0d,%0d want %0d,%0d", b0_q[0].cyc, b0_q[1].cyc, c0, c1); end
      end

      // MWr64 at 0x1FF0, len 6, firstBE 3 lastBE C: partial BEs and address wrap
      b0_q.delete();
      send({32'h0000_1FF0, 32'h0, 32'h0100_02C3, mk_dw0(8'h60, 3'd0, 3'd0, 10'd6)}, 1'b0, 6'b000001);
      send(d2, 1'b0, 6'b000001);
      send(d3, 1'b1, 6'b000001);
      idle(3);
      n_cmp++; if (b0_q.size() != 2) begin n_bad++; $display("FAIL mwr64_count: got %0d want 2", b0_q.size()); end
      if (b0_q.size() == 2) begin
         n_cmp++; if (b0_q[0].addr !== 9'h1FF || b0_q[1].addr !== 9'h000) begin n_bad++; $display("FAIL mwr64_wrap_addr: got %h,%h want 1ff,000", b0_q[0].addr, b0_q[1].addr); end
         n_cmp++; if (b0_q[0].be !== 16'hFFF3) begin n_bad++; $display("FAIL mwr64_first_be: got %h want fff3", b0_q[0].be); end
         n_cmp++; if (b0_q[1].be !== 16'h00CF) begin n_bad++; $display("FAIL mwr64_last_be: got %h want 00cf", b0_q[1].be); end
         n_cmp++; if (b0_q[1].data !== d3) begin n_bad++; $display("FAIL mwr64_data: got %h want %h", b0_q[1].data, d3); end
      end
   endtask

   task automatic test_mwr_bar1();
      int b1_0;
      b0_q.delete();
      b1_0 = n_b1;
      send({32'h0, 32'h0000_0010, 32'h0100_030F, mk_dw0(8'h40, 3'd0, 3'd0, 10'd1)}, 1'b0, 6'b000010);
      send({96'h0, 32'h0000_1234}, 1'b1, 6'b000010);
      idle(3);
      n_cmp++; if (n_b1 != b1_0 + 1) begin n_bad++; $display("FAIL bar1_count: got %0d want %0d", n_b1, b1_0 + 1); end
      n_cmp++; if (last_b1_addr !== 8'h10) begin n_bad++; $display("FAIL bar1_addr: got %h want 10", last_b1_addr); end
      n_cmp++; if (last_b1_data !== 32'h0000_1234) begin n_bad++; $display("FAIL bar1_data: got %h want 00001234", last_b1_data); end
      n_cmp++; if (b0_q.size() != 0) begin n_bad++; $display("FAIL bar1_no_bar0: got %0d bar0 writes want 0", b0_q.size()); end
   endtask

   task automatic test_mrd();
      req_rdy = 1'b0;
      // MRd64 tc 2 attr 101 len 16 id ABCD tag 05
      send({32'h2345_6780, 32'h0000_0001, 32'hABCD_05FF, mk_dw0(8'h20, 3'd2, 3'b101, 10'd16)}, 1'b1, 6'b000001);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++; if (trdy !== 1'b0) begin n_bad++; $display("FAIL mrd_hold_trdy[%0d]: got %b want 0", k, trdy); end
         n_cmp++; if (req_vld !== 1'b1) begin n_bad++; $display("FAIL mrd_hold_vld[%0d]: got %b want 1", k, req_vld); end
         n_cmp++; if (mrd_addr !== 64'h0000_0001_2345_6780) begin n_bad++; $display("FAIL mrd_addr[%0d]: got %h want 0000000123456780", k, mrd_addr); end
         n_cmp++; if (mrd_tag !== 8'h05 || mrd_id !== 16'hABCD) begin n_bad++; $display("FAIL mrd_tag_id[%0d]: got %h/%h want 05/abcd", k, mrd_tag, mrd_id); end
         n_cmp++; if (mrd_length !== 10'd16 || mrd_tc !== 3'd2 || mrd_attr !== 3'b101) begin n_bad++; $display("FAIL mrd_len_tc_attr[%0d]: got %0d/%0d/%b want 16/2/101", k, mrd_length, mrd_tc, mrd_attr); end
      end
      @(posedge clk); #2;
      req_rdy = 1'b1;
      @(posedge clk); #2;
      req_rdy = 1'b0;
      @(negedge clk);
      n_cmp++; if (req_vld !== 1'b0) begin n_bad++; $display("FAIL mrd_vld_drop: got %b want 0", req_vld); end
      n_cmp++; if (trdy !== 1'b1) begin n_bad++; $display("FAIL mrd_back_idle: got trdy %b want 1", trdy); end
      @(posedge clk); #2;

      // MRd32 accepted immediately: upper address is zero
      req_rdy = 1'b1;
      send({32'h0, 32'h8000_0010, 32'h1111_22FF, mk_dw0(8'h00, 3'd0, 3'd0, 10'd1)}, 1'b1, 6'b000001);
      @(negedge clk);
      n_cmp++; if (req_vld !== 1'b1) begin n_bad++; $display("FAIL mrd32_vld: got %b want 1", req_vld); end
      n_cmp++; if (mrd_addr !== 64'h0000_0000_8000_0010) begin n_bad++; $display("FAIL mrd32_addr: got %h want 0000000080000010", mrd_addr); end
      n_cmp++; if (mrd_id !== 16'h1111 || mrd_tag !== 8'h22) begin n_bad++; $display("FAIL mrd32_id_tag: got %h/%h want 1111/22", mrd_id, mrd_tag); end
      @(negedge clk);
      n_cmp++; if (req_vld !== 1'b0) begin n_bad++; $display("FAIL mrd32_vld_drop: got %b want 0", req_vld); end
      req_rdy = 1'b0;
      idle(1);
   endtask

   task automatic test_cpld();
      logic [127:0] dc;
      int r0;
      dc = 128'hc0c1c2c3_c4c5c6c7_c8c9cacb_cccdcecf;
      b2_q.delete();
      r0 = n_rcv;
      // tag 07 len 4 bc 16: final completion
      send({32'h0, 32'h0000_0700, 32'h0100_0010, mk_dw0(8'h4A, 3'd0, 3'd0, 10'd4)}, 1'b0, 6'b000000);
      send(dc, 1'b1, 6'b000000);
      idle(2);
      n_cmp++; if (b2_q.size() != 1) begin n_bad++; $display("FAIL cpld_count: got %0d want 1", b2_q.size()); end
      if (b2_q.size() == 1) begin
         n_cmp++; if (b2_q[0].addr !== 9'd0) begin n_bad++; $display("FAIL cpld_ptr0: got %h want 000", b2_q[0].addr); end
         n_cmp++; if (b2_q[0].be !== 16'hFFFF || b2_q[0].data !== dc) begin n_bad++; $display("FAIL cpld_be_data: got %h/%h want ffff/%h", b2_q[0].be, b2_q[0].data, dc); end
      end
      n_cmp++; if (n_rcv != r0 + 1 || last_rcv_tag !== 8'h07) begin n_bad++; $display("FAIL cpld_rcv: got %0d pulses tag %h want 1 tag 07", n_rcv - r0, last_rcv_tag); end
      n_cmp++; if (rcv_cyc != hs_cyc - 1) begin n_bad++; $display("FAIL cpld_rcv_timing: got cyc %0d want %0d", rcv_cyc, hs_cyc - 1); end

      // tag 08 bc 64 > len*4: data written, tag not released
      send({32'h0, 32'h0000_0800, 32'h0100_0040, mk_dw0(8'h4A, 3'd0, 3'd0, 10'd4)}, 1'b0, 6'b000000);
      send(dc, 1'b1, 6'b000000);
      idle(2);
      n_cmp++; if (n_rcv != r0 + 1) begin n_bad++; $display("FAIL cpld_partial_no_rcv: got %0d pulses want 1", n_rcv - r0); end
      n_cmp++; if (b2_q.size() != 2 || b2_q[b2_q.size()-1].addr !== 9'd1) begin n_bad++; $display("FAIL cpld_ptr1: got %0d writes last addr %h want 2 writes addr 001", b2_q.size(), b2_q[b2_q.size()-1].addr); end

      // tag 09 with restart on the data beat: write uses pointer 2, pointer then 0
      send({32'h0, 32'h0000_0900, 32'h0100_0010, mk_dw0(8'h4A, 3'd0, 3'd0, 10'd4)}, 1'b0, 6'b000000);
      rx_restart = 1'b1;
      send(dc, 1'b1, 6'b000000);
      rx_restart = 1'b0;
      idle(2);
      n_cmp++; if (b2_q.size() != 3 || b2_q[b2_q.size()-1].addr !== 9'd2) begin n_bad++; $display("FAIL cpld_restart_old_ptr: got %0d writes last addr %h want 3 writes addr 002", b2_q.size(), b2_q[b2_q.size()-1].addr); end
      n_cmp++; if (n_rcv != r0 + 2 || last_rcv_tag !== 8'h09) begin n_bad++; $display("FAIL cpld_rcv_tag09: got %0d pulses tag %h want 2 tag 09", n_rcv - r0, last_rcv_tag); end

      // tag 0A len 2 bc 8 after restart: pointer 0, two lanes enabled
      send({32'h0, 32'h0000_0A00, 32'h0100_0008, mk_dw0(8'h4A, 3'd0, 3'd0, 10'd2)}, 1'b0, 6'b000000);
      send(dc, 1'b1, 6'b000000);
      idle(2);
      n_cmp++; if (b2_q.size() != 4 || b2_q[b2_q.size()-1].addr !== 9'd0) begin n_bad++; $display("FAIL cpld_after_restart_ptr: got %0d writes last addr %h want 4 writes addr 000", b2_q.size(), b2_q[b2_q.size()-1].addr); end
      n_cmp++; if (b2_q[b2_q.size()-1].be !== 16'h00FF) begin n_bad++; $display("FAIL cpld_len2_be: got %h want 00ff", b2_q[b2_q.size()-1].be); end
      n_cmp++; if (n_rcv != r0 + 3 || last_rcv_tag !== 8'h0A) begin n_bad++; $display("FAIL cpld_rcv_tag0a: got %0d pulses tag %h want 3 tag 0a", n_rcv - r0, last_rcv_tag); end
   endtask

   task automatic test_unsupported();
      int u0, b1_0, b2_0;
      b0_q.delete();
      u0 = n_unsup; b1_0 = n_b1; b2_0 = b2_q.size();
      // Cpl without data
      send({32'h0, 32'h0000_0B00, 32'h0100_0000, mk_dw0(8'h0A, 3'd0, 3'd0, 10'd0)}, 1'b1, 6'b000000);
      idle(2);
      n_cmp++; if (n_unsup != u0 + 1) begin n_bad++; $display("FAIL unsup_cpl: got %0d pulse cycles want 1", n_unsup - u0); end
      // MWr header carrying tlast
      send({32'h0, 32'h0000_0080, 32'h0100_00FF, mk_dw0(8'h40, 3'd0, 3'd0, 10'd4)}, 1'b1, 6'b000001);
      idle(2);
      n_cmp++; if (n_unsup != u0 + 2) begin n_bad++; $display("FAIL unsup_mwr_tlast: got %0d pulse cycles want 2", n_unsup - u0); end
      // MWr hitting BAR2 is discarded along with its payload
      send({32'h0, 32'h0000_0000, 32'h0100_00FF, mk_dw0(8'h40, 3'd0, 3'd0, 10'd8)}, 1'b0, 6'b000100);
      send(128'h1, 1'b0, 6'b000100);
      send(128'h2, 1'b1, 6'b000100);
      idle(2);
      n_cmp++; if (n_unsup != u0 + 3) begin n_bad++; $display("FAIL unsup_discard: got %0d pulse cycles want 3", n_unsup - u0); end
      n_cmp++; if (b0_q.size() != 0 || n_b1 != b1_0 || b2_q.size() != b2_0) begin n_bad++; $display("FAIL unsup_no_writes: got bar0 %0d bar1 %0d bar2 %0d want 0/0/0", b0_q.size(), n_b1 - b1_0, b2_q.size() - b2_0); end
      // Next TLP decodes normally: MWr32 0x30 len 1 firstBE 6
      send({32'h0, 32'h0000_0030, 32'h0100_0406, mk_dw0(8'h40, 3'd0, 3'd0, 10'd1)}, 1'b0, 6'b000001);
      send(128'h0000_0000_0000_0000_0000_0000_abcd_ef01, 1'b1, 6'b000001);
      idle(2);
      n_cmp++; if (b0_q.size() != 1) begin n_bad++; $display("FAIL unsup_recover_count: got %0d want 1", b0_q.size()); end
      if (b0_q.size() == 1) begin
         n_cmp++; if (b0_q[0].addr !== 9'd3 || b0_q[0].be !== 16'h0006) begin n_bad++; $display("FAIL unsup_recover_write: got addr %h be %h want 003/0006", b0_q[0].addr, b0_q[0].be); end
      end
   endtask

   task automatic test_reset_mid();
      b0_q.delete();
      b2_q.delete();
      // MWr32 len 32 at 0x200: two beats, then reset with the third beat on the bus
      send({32'h0, 32'h0000_0200, 32'h0100_05FF, mk_dw0(8'h40, 3'd0, 3'd0, 10'd32)}, 1'b0, 6'b000001);
      send(128'hA1, 1'b0, 6'b000001);
      send(128'hA2, 1'b0, 6'b000001);
      tvld = 1'b1; tdata = 128'hA3; tuser = 6'b000001;
      rst = 1'b1;
      @(posedge clk); #2;
      @(negedge clk);
      n_cmp++; if ({b0_en, b1_en, b2_en, unsupported, req_vld} !== 5'b0) begin n_bad++; $display("FAIL rst_mid_strobes: got %b want 00000", {b0_en, b1_en, b2_en, unsupported, req_vld}); end
      n_cmp++; if (b0_addr !== '0 || b0_be !== '0 || b0_data !== '0) begin n_bad++; $display("FAIL rst_mid_bar0_bus: got %h/%h/%h want 0", b0_addr, b0_be, b0_data); end
      n_cmp++; if (trdy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_trdy: got %b want 1", trdy); end
      @(posedge clk); #2;
      rst = 1'b0; tvld = 1'b0; tdata = '0; tuser = '0;
      idle(5);
      n_cmp++; if (b0_q.size() != 2) begin n_bad++; $display("FAIL rst_mid_no_more_writes: got %0d want 2", b0_q.size()); end
      if (b0_q.size() == 2) begin
         n_cmp++; if (b0_q[0].addr !== 9'h020 || b0_q[1].addr !== 9'h021) begin n_bad++; $display("FAIL rst_mid_pre_addrs: got %h,%h want 020,021", b0_q[0].addr, b0_q[1].addr); end
      end
      // BAR2 pointer was 1 before reset; reset returns it to 0
      send({32'h0, 32'h0000_0C00, 32'h0100_0010, mk_dw0(8'h4A, 3'd0, 3'd0, 10'd4)}, 1'b0, 6'b000000);
      send(128'hC0, 1'b1, 6'b000000);
      idle(2);
      n_cmp++; if (b2_q.size() != 1 || b2_q[0].addr !== 9'd0) begin n_bad++; $display("FAIL rst_mid_bar2_ptr: got %0d writes addr %h want 1 write addr 000", b2_q.size(), b2_q[0].addr); end
   endtask

   initial begin
      test_reset();
      test_mwr_bar0();
      test_mwr_bar1();
      test_mrd();
      test_cpld();
      test_unsupported();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
